// File: rtl/mem_line_burst_engine_pkg.sv
// Memory beat types and line-engine definitions shared by the line burst engine and its bench.
// Holds the request/response beat structs, engine state encoding and line-address helpers.
package mem_line_burst_engine_pkg;

  localparam int ADDR_WIDTH              = 32;
  localparam int CORE_ID_WIDTH           = 4;
  localparam int DEFAULT_CACHE_LINE_SIZE = 32;
  localparam int LINE_WORDS              = DEFAULT_CACHE_LINE_SIZE / 4;
  localparam int OFFSET_BITS             = $clog2(DEFAULT_CACHE_LINE_SIZE);

  typedef logic [ADDR_WIDTH-1:0] addr_t;

  typedef struct packed {
    logic [3:0]               id;
    logic [CORE_ID_WIDTH-1:0] source_id;
    addr_t                    addr;
    logic [31:0]              data;
    logic [3:0]               strb;
    logic                     write;
    logic [7:0]               burst_len;
    logic                     burst_last;
    logic                     coherent;
    logic                     cacheable;
    logic [2:0]               prot;
    logic [2:0]               size;
  } memory_req_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] data;
    logic        error;
    logic        last;
  } memory_rsp_t;

  typedef enum logic [2:0] {
    LE_IDLE    = 3'd0,
    LE_RD_REQ  = 3'd1,
    LE_RD_DATA = 3'd2,
    LE_WR_DATA = 3'd3,
    LE_WR_RESP = 3'd4,
    LE_DONE    = 3'd5
  } line_engine_state_e;

  function automatic addr_t line_base_addr(input addr_t addr);
    return {addr[ADDR_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
  endfunction

endpackage

// File: rtl/mem_line_burst_engine.sv
// Line fill/writeback to beat-burst converter: fill = 1 request beat + W data beats, writeback = W beats + 1 response.
// Latency accept->completion is W+2 cycles unstalled; beats hold until handshake, completion holds until line_rsp_ready_i.
module mem_line_burst_engine
  import mem_line_burst_engine_pkg::*;
#(
  parameter int                       LINE_BYTES = LINE_WORDS * 4,
  parameter logic [3:0]               TXN_ID     = 4'h0,
  parameter logic [CORE_ID_WIDTH-1:0] SOURCE_ID  = '0
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    line_req_valid_i,
  output logic                    line_req_ready_o,
  input  logic                    line_req_write_i,
  input  addr_t                   line_req_addr_i,
  input  logic [LINE_BYTES*8-1:0] line_wdata_i,
  output logic                    line_rsp_valid_o,
  input  logic                    line_rsp_ready_i,
  output logic [LINE_BYTES*8-1:0] line_rdata_o,
  output logic                    line_rsp_error_o,
  output logic                    mem_req_valid_o,
  input  logic                    mem_req_ready_i,
  output memory_req_t             mem_req_o,
  input  logic                    mem_rsp_valid_i,
  output logic                    mem_rsp_ready_o,
  input  memory_rsp_t             mem_rsp_i
);

  localparam int W  = LINE_BYTES / 4;
  localparam int CW = $clog2(W);

  line_engine_state_e      state_q;
  logic [CW-1:0]           cnt_q;
  logic                    err_q;
  logic [LINE_BYTES*8-1:0] rbuf_q;
  logic [LINE_BYTES*8-1:0] wbuf_q;
  addr_t                   base_q;

  logic  cnt_last;
  logic  rsp_bad;
  addr_t req_base;

  assign cnt_last = (cnt_q == CW'(W - 1));
  assign rsp_bad  = mem_rsp_i.error | (mem_rsp_i.id != TXN_ID);
  assign req_base = line_req_addr_i & ~addr_t'(LINE_BYTES - 1);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= LE_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      rbuf_q  <= '0;
      wbuf_q  <= '0;
      base_q  <= '0;
    end else begin
      case (state_q)
        LE_IDLE: if (line_req_valid_i) begin
          base_q <= req_base;
          wbuf_q <= line_wdata_i;
          err_q  <= 1'b0;
          cnt_q  <= '0;
          if (line_req_write_i) begin
            state_q <= LE_WR_DATA;
          end else begin
            rbuf_q  <= '0;
            state_q <= LE_RD_REQ;
          end
        end
        LE_RD_REQ: if (mem_req_ready_i) state_q <= LE_RD_DATA;
        LE_RD_DATA: if (mem_rsp_valid_i) begin
          rbuf_q[cnt_q*32 +: 32] <= mem_rsp_i.data;
          cnt_q <= cnt_q + CW'(1);
          // last must coincide exactly with the final word; early or missing last is an error
          err_q <= err_q | rsp_bad | (cnt_last != mem_rsp_i.last);
          if (cnt_last || mem_rsp_i.last) state_q <= LE_DONE;
        end
        LE_WR_DATA: if (mem_req_ready_i) begin
          cnt_q <= cnt_q + CW'(1);
          if (cnt_last) state_q <= LE_WR_RESP;
        end
        LE_WR_RESP: if (mem_rsp_valid_i) begin
          err_q   <= err_q | rsp_bad | ~mem_rsp_i.last;
          state_q <= LE_DONE;
        end
        LE_DONE: if (line_rsp_ready_i) state_q <= LE_IDLE;
        default: state_q <= LE_IDLE;
      endcase
    end
  end

  assign line_req_ready_o = (state_q == LE_IDLE);
  assign mem_req_valid_o  = (state_q == LE_RD_REQ) || (state_q == LE_WR_DATA);
  assign mem_rsp_ready_o  = (state_q == LE_RD_DATA) || (state_q == LE_WR_RESP);
  assign line_rsp_valid_o = (state_q == LE_DONE);
  assign line_rdata_o     = rbuf_q;
  assign line_rsp_error_o = err_q;

  // Payload is zero whenever no beat is offered so idle/reset outputs are all-zero.
  always_comb begin
    mem_req_o = '0;
    if (mem_req_valid_o) begin
      mem_req_o.id         = TXN_ID;
      mem_req_o.source_id  = SOURCE_ID;
      mem_req_o.write      = (state_q == LE_WR_DATA);
      mem_req_o.burst_len  = 8'(W);
      mem_req_o.cacheable  = 1'b1;
      mem_req_o.size       = 3'b010;
      if (state_q == LE_WR_DATA) begin
        mem_req_o.addr       = base_q + addr_t'({cnt_q, 2'b00});
        mem_req_o.data       = wbuf_q[cnt_q*32 +: 32];
        mem_req_o.strb       = 4'hF;
        mem_req_o.burst_last = cnt_last;
      end else begin
        mem_req_o.addr       = base_q;
        mem_req_o.burst_last = 1'b1;
      end
    end
  end

endmodule
